// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared UART TX definitions: FSM state encoding, parity types, line levels
// and a counter-width helper used by the frame controller.
package uart_tx_frame_ctrl_pkg;

  // Frame controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity type selector values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Counter width for a count of n states; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Handshake/serial bundle between the word source, the TX serializer and the
// frame controller.
//   master : drives Data, Data_valid, PAR_EN, PAR_TYP, Ser_data;
//            observes Ser_load, Ser_EN, TX_OUT, Busy
//   slave  : the frame controller (mirror of master)
interface uart_tx_frame_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] Data;
  logic             Data_valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             Ser_data;
  logic             Ser_load;
  logic             Ser_EN;
  logic             TX_OUT;
  logic             Busy;

  modport master (
    output Data, Data_valid, PAR_EN, PAR_TYP, Ser_data,
    input  Ser_load, Ser_EN, TX_OUT, Busy
  );

  modport slave (
    input  Data, Data_valid, PAR_EN, PAR_TYP, Ser_data,
    output Ser_load, Ser_EN, TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity bit generator.
//   data    : word to protect (WIDTH bits)
//   par_typ : PAR_EVEN / PAR_ODD
//   par_bit : bit that makes the total count of ones even or odd
module uart_tx_parity_calc
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par_bit
);

  // Even parity is the plain XOR reduction; odd parity inverts it
  assign par_bit = (par_typ == PAR_EVEN) ? (^data) : ~(^data);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller. Loads and paces the downstream serializer and
// builds the line frame: start bit, WIDTH data bits LSB-first, optional
// parity bit, STOP_BITS stop bits. One CLK cycle is one bit period.
//   CLK   : baud clock
//   Reset : synchronous, active-high
//   bus   : slave side of uart_tx_frame_ctrl_if
//           Ser_load, Ser_EN, Busy are state/request decodes;
//           TX_OUT is registered and lags the state by one cycle
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  uart_tx_frame_ctrl_if.slave  bus
);

  localparam int unsigned BIT_W = cnt_width(WIDTH);
  localparam int unsigned SC_W  = cnt_width(STOP_BITS);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [SC_W-1:0]  STOP_LAST = SC_W'(STOP_BITS - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SC_W-1:0]  stop_cnt_q, stop_cnt_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             tx_q;
  logic             line_c;
  logic             accept_c;
  logic             ser_en_c;
  logic             busy_c;
  logic             par_calc_c;
  logic             last_stop_c;

  // Parity of the incoming word, latched only at accept
  uart_tx_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data    (bus.Data),
    .par_typ (bus.PAR_TYP),
    .par_bit (par_calc_c)
  );

  assign last_stop_c = (state_q == ST_STOP) && (stop_cnt_q == STOP_LAST);

  // Requests are taken when idle or in the final stop cycle (back-to-back)
  assign accept_c = bus.Data_valid && ((state_q == ST_IDLE) || last_stop_c);

  // State, counters, latched config and the line register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      tx_q       <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      tx_q       <= line_c;
    end
  end

  // Next-state, counter updates and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    line_c     = LINE_IDLE;
    ser_en_c   = 1'b0;
    busy_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        line_c = LINE_IDLE;
      end
      ST_START: begin
        // First shift here so data bit 0 is on Ser_data in the first DATA cycle
        line_c    = START_BIT;
        ser_en_c  = 1'b1;
        busy_c    = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        line_c = bus.Ser_data;
        busy_c = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          stop_cnt_d = '0;
          state_d    = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          // START plus WIDTH-1 data cycles gives exactly WIDTH shifts
          ser_en_c  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_PARITY: begin
        line_c     = par_bit_q;
        busy_c     = 1'b1;
        stop_cnt_d = '0;
        state_d    = ST_STOP;
      end
      ST_STOP: begin
        line_c = LINE_IDLE;
        if (last_stop_c) begin
          state_d = ST_IDLE;
        end else begin
          busy_c     = 1'b1;
          stop_cnt_d = stop_cnt_q + SC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept overrides the IDLE/STOP transition and snapshots the config
    if (accept_c) begin
      state_d   = ST_START;
      par_bit_d = par_calc_c;
      par_en_d  = bus.PAR_EN;
    end
  end

  assign bus.Ser_load = accept_c;
  assign bus.Ser_EN   = ser_en_c;
  assign bus.Busy     = busy_c;
  assign bus.TX_OUT   = tx_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl. dut1 uses STOP_BITS=1, dut2 uses
// STOP_BITS=2; both share the request inputs and each has its own shift
// register serializer model. Expected frames are hand-written constants with
// bit 0 = first bit on the line and all unused upper bits at idle (1).
module tb_uart_tx_frame_ctrl;
  import uart_tx_frame_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dv;
  logic       pe;
  logic       pt;

  int checks = 0;
  int passed = 0;

  // capture / accumulators filled by step()
  logic [31:0] cap1, cap2;
  int k, busy1_n, busy2_n, en1_n, load1_n, overlap;

  // serializer models
  logic [7:0] sreg1 = 8'h00, sreg2 = 8'h00;
  logic       ser1_q = 1'b1, ser2_q = 1'b1;

  uart_tx_frame_ctrl_if #(.WIDTH(8)) bus1 ();
  uart_tx_frame_ctrl_if #(.WIDTH(8)) bus2 ();

  assign bus1.Data       = data;
  assign bus1.Data_valid = dv;
  assign bus1.PAR_EN     = pe;
  assign bus1.PAR_TYP    = pt;
  assign bus1.Ser_data   = ser1_q;
  assign bus2.Data       = data;
  assign bus2.Data_valid = dv;
  assign bus2.PAR_EN     = pe;
  assign bus2.PAR_TYP    = pt;
  assign bus2.Ser_data   = ser2_q;

  uart_tx_frame_ctrl #(.WIDTH(8), .STOP_BITS(1)) u_dut1 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus1.slave)
  );

  uart_tx_frame_ctrl #(.WIDTH(8), .STOP_BITS(2)) u_dut2 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  // serializer: load on Ser_load, present LSB and shift on Ser_EN
  always @(posedge clk) begin
    if (bus1.Ser_load) sreg1 <= data;
    else if (bus1.Ser_EN) begin
      ser1_q <= sreg1[0];
      sreg1  <= sreg1 >> 1;
    end
    if (bus2.Ser_load) sreg2 <= data;
    else if (bus2.Ser_EN) begin
      ser2_q <= sreg2[0];
      sreg2  <= sreg2 >> 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_acc();
    cap1 = '1; cap2 = '1;
    k = 0; busy1_n = 0; busy2_n = 0; en1_n = 0; load1_n = 0; overlap = 0;
  endtask

  // Sample the current cycle, then advance one clock; requests last one cycle
  task automatic step();
    #1;
    if (k >= 2 && k < 34) begin
      cap1[k-2] = bus1.TX_OUT;
      cap2[k-2] = bus2.TX_OUT;
    end
    if (bus1.Busy) busy1_n++;
    if (bus2.Busy) busy2_n++;
    if (bus1.Ser_EN) en1_n++;
    if (bus1.Ser_load) load1_n++;
    if (bus1.Ser_EN && bus1.Ser_load) overlap++;
    k++;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic p_en, input logic p_typ);
    data = d; pe = p_en; pt = p_typ; dv = 1'b1;
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; data = 8'h00; pe = 1'b0; pt = PAR_EVEN;
    clear_acc();
    step(); step();
    chk("rst_tx",   32'(bus1.TX_OUT),   32'd1);
    chk("rst_busy", 32'(bus1.Busy),     32'd0);
    chk("rst_en",   32'(bus1.Ser_EN),   32'd0);
    chk("rst_load", 32'(bus1.Ser_load), 32'd0);
    rst = 1'b0;

    // idle: {TX_OUT, Busy, Ser_EN} stays 3'b100
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", 32'({bus1.TX_OUT, bus1.Busy, bus1.Ser_EN}), 32'h4);
    end

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle
    clear_acc();
    send(8'hA5, 1'b0, PAR_EVEN);
    repeat (14) step();
    chk("a5_frame",   cap1,           32'hFFFF_FF4A);
    chk("a5_busy",    32'(busy1_n),   32'd9);
    chk("a5_en",      32'(en1_n),     32'd8);
    chk("a5_load",    32'(load1_n),   32'd1);
    chk("a5_overlap", 32'(overlap),   32'd0);

    // 0xA5 even parity -> parity bit 0
    clear_acc();
    send(8'hA5, 1'b1, PAR_EVEN);
    repeat (14) step();
    chk("a5e_frame", cap1,         32'hFFFF_FD4A);
    chk("a5e_busy",  32'(busy1_n), 32'd10);
    chk("a5e_en",    32'(en1_n),   32'd8);

    // 0xA5 odd parity -> parity bit 1
    clear_acc();
    send(8'hA5, 1'b1, PAR_ODD);
    repeat (14) step();
    chk("a5o_frame", cap1,         32'hFFFF_FF4A);
    chk("a5o_busy",  32'(busy1_n), 32'd10);
    chk("a5o_en",    32'(en1_n),   32'd8);

    // 0x07 even parity -> parity bit 1
    clear_acc();
    send(8'h07, 1'b1, PAR_EVEN);
    repeat (14) step();
    chk("07e_frame", cap1,         32'hFFFF_FE0E);
    chk("07e_busy",  32'(busy1_n), 32'd10);
    chk("07e_en",    32'(en1_n),   32'd8);

    // back-to-back: 0x3C requested in the final stop cycle of 0xA5
    clear_acc();
    send(8'hA5, 1'b0, PAR_EVEN);
    repeat (10) step();
    chk("b2b_stop_busy", 32'(bus1.Busy), 32'd0);
    send(8'h3C, 1'b0, PAR_EVEN);
    repeat (16) step();
    chk("b2b_frames",  cap1,           32'hFFF9_E34A);
    chk("b2b_load",    32'(load1_n),   32'd2);
    chk("b2b_busy",    32'(busy1_n),   32'd18);
    chk("b2b_overlap", 32'(overlap),   32'd0);

    // request with 0xFF during DATA is ignored
    clear_acc();
    send(8'hA5, 1'b0, PAR_EVEN);
    repeat (5) step();
    send(8'hFF, 1'b1, PAR_ODD);
    repeat (9) step();
    chk("drop_frame", cap1,         32'hFFFF_FF4A);
    chk("drop_load",  32'(load1_n), 32'd1);
    chk("drop_busy",  32'(busy1_n), 32'd9);

    // reset at bit_cnt=3 aborts the frame
    clear_acc();
    send(8'hA5, 1'b0, PAR_EVEN);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("abort_tx",    32'(bus1.TX_OUT), 32'd1);
    chk("abort_busy",  32'(bus1.Busy),   32'd0);
    chk("abort_en",    32'(bus1.Ser_EN), 32'd0);
    chk("abort_tx2",   32'(bus2.TX_OUT), 32'd1);
    rst = 1'b0;
    step();

    // 0x55 on both builds; STOP_BITS=2 keeps Busy one extra stop cycle
    clear_acc();
    send(8'h55, 1'b0, PAR_EVEN);
    repeat (14) step();
    chk("55_frame1", cap1,         32'hFFFF_FEAA);
    chk("55_frame2", cap2,         32'hFFFF_FEAA);
    chk("55_busy1",  32'(busy1_n), 32'd9);
    chk("55_busy2",  32'(busy2_n), 32'd10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
